// File: rtl/lock_pkg.sv
// Shared types and default constants for the code-entry lock controller.
package lock_pkg;

  // Controller modes; 2-bit encoding.
  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_e;

  localparam int DEF_DIGITS         = 4;
  localparam int DEF_IDX_W          = 3;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_UNLOCK_CYCLES  = 8;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  // Width of the consecutive-failure counter port.
  localparam int FAIL_W = 3;

  // Bits needed for a down-counter that is loaded with (longest period - 1).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/code_lock_seq_edge_detect.sv
// Rising-edge detector for the enter switch. The delayed copy resets to 1 so
// a switch that is already held high when reset is released is not counted.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Delay the input by one cycle; tracked in every controller mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/code_lock_seq.sv
// Code-entry controller: steps the digit index presented to the external
// 2-bit equality comparator, samples its eq result on each enter press, and
// after a full code either opens the lock or counts a failure, with lockout.
module code_lock_seq
  import lock_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter,
  input  logic              clear,
  input  logic              eq,
  output logic [IDX_W-1:0]  digit_idx,
  output logic              unlocked,
  output logic              locked_out,
  output logic              err,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam int TMR_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0]  UNLOCK_INIT = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_INIT   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAILS);

  logic press;

  lock_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mismatch_q, mismatch_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_q, locked_d;

  logic last_digit;
  logic code_bad;
  logic limit_hit;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (enter),
    .rise_o (press)
  );

  // The final press folds its own eq into the accumulated mismatch, so a
  // wrong digit anywhere only becomes visible after the full code.
  assign last_digit = (idx_q == LAST_IDX);
  assign code_bad   = mismatch_q | ~eq;
  assign limit_hit  = ((fail_q + FAIL_W'(1)) == FAIL_LIMIT);

  // State and datapath registers, including the state-decoded output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state logic: digit stepping, code verdict, timers and fail counting.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    err_d      = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          // Abort wins over a press in the same cycle; failures are kept.
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (press) begin
          if (!last_digit) begin
            mismatch_d = code_bad;
            idx_d      = idx_q + IDX_W'(1);
          end else begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!code_bad) begin
              state_d = ST_OPEN;
              fail_d  = '0;
              timer_d = UNLOCK_INIT;
            end else begin
              err_d = 1'b1;
              if (fail_q != FAIL_LIMIT) begin
                fail_d = fail_q + FAIL_W'(1);
              end
              if (limit_hit) begin
                state_d = ST_LOCKOUT;
                timer_d = LOCK_INIT;
              end
            end
          end
        end
      end

      ST_OPEN: begin
        // Presses are ignored; clear relocks early.
        if (clear || (timer_q == '0)) begin
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_LOCKOUT: begin
        // Presses and clear are ignored until the penalty expires.
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  // Output decode from the next state, so the LED flops track the mode.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
    locked_d   = (state_d == ST_LOCKOUT);
  end

  assign digit_idx  = idx_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign err        = err_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_seq.sv
// Self-checking bench for code_lock_seq: a stored 2-bit code plus the
// equality comparator sit around the DUT, and a queue-based reference model
// predicts every output after every clock edge.
module tb_code_lock_seq;

  localparam int DIGITS         = 4;
  localparam int IDX_W          = 3;
  localparam int MAX_FAILS      = 3;
  localparam int UNLOCK_CYCLES  = 8;
  localparam int LOCKOUT_CYCLES = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enter = 1'b0;
  logic             clear = 1'b0;
  logic             eq;
  logic [1:0]       sw = 2'd0;
  logic [IDX_W-1:0] digit_idx;
  logic             unlocked;
  logic             locked_out;
  logic             err;
  logic [2:0]       fail_cnt;
  logic [1:0]       code [0:7];
  logic [8:0]       obs;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_q[$];      // eq results of the digits entered so far
  int m_fails = 0;
  int m_open  = 0; // unlocked cycles remaining
  int m_lock  = 0; // lockout cycles remaining
  bit m_err   = 0;
  bit m_prev  = 1;

  always #5 clk = ~clk;

  // Comparator: XNOR pair into AND against the selected stored digit.
  assign eq  = &(~(sw ^ code[digit_idx]));
  assign obs = {digit_idx, unlocked, locked_out, err, fail_cnt};

  code_lock_seq #(
    .DIGITS         (DIGITS),
    .IDX_W          (IDX_W),
    .MAX_FAILS      (MAX_FAILS),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .clear      (clear),
    .eq         (eq),
    .digit_idx  (digit_idx),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .err        (err),
    .fail_cnt   (fail_cnt)
  );

  function automatic logic [8:0] exp_vec();
    return {3'(m_q.size()), (m_open > 0), (m_lock > 0), m_err, 3'(m_fails)};
  endfunction

  // One clock of the behavioural model, from the rules of the lock.
  task automatic model_step(input bit en, input bit cl, input bit rs, input bit good);
    bit press;
    bit all_ok;
    if (rs) begin
      m_q.delete();
      m_fails = 0; m_open = 0; m_lock = 0; m_err = 0; m_prev = 1;
      return;
    end
    press  = en && !m_prev;
    m_prev = en;
    m_err  = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_open > 0) begin
      if (cl) m_open = 0;
      else    m_open--;
    end else if (cl) begin
      m_q.delete();
    end else if (press) begin
      m_q.push_back(good);
      $display("press: digit %0d eq=%0b", m_q.size() - 1, good);
      if (m_q.size() == DIGITS) begin
        all_ok = 1;
        foreach (m_q[i]) if (!m_q[i]) all_ok = 0;
        if (all_ok) begin
          m_open  = UNLOCK_CYCLES;
          m_fails = 0;
          $display("code accepted");
        end else begin
          m_err = 1;
          m_fails++;
          if (m_fails == MAX_FAILS) m_lock = LOCKOUT_CYCLES;
          $display("code rejected, fails=%0d", m_fails);
        end
        m_q.delete();
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then advance the model.
  // good selects switches that match (or differ from) the digit the model
  // expects to be under test.
  task automatic tick(input bit en, input bit cl, input bit rs, input bit good);
    int idx;
    @(negedge clk);
    enter = en; clear = cl; rst = rs;
    idx = m_q.size();
    sw  = good ? code[idx] : (code[idx] ^ 2'($urandom_range(1, 3)));
    @(posedge clk);
    model_step(en, cl, rs, good);
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b", obs, 9'd0);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_unlock();
    int high = 0;
    int errs = 0;
    for (int p = 0; p < DIGITS; p++) begin
      tick(1, 0, 0, 1);
      high += unlocked; errs += err;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL unlock_press%0d got=%b want=%b", p, obs, exp_vec());
      end
      if (p < DIGITS - 1) begin
        tick(0, 0, 0, 1);
        errs += err;
      end
    end
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0, 1);
      high += unlocked; errs += err;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL unlock_hold%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    checks++;
    if (high != UNLOCK_CYCLES || errs != 0) begin
      errors++;
      $display("FAIL unlock_len got high=%0d err=%0d want high=%0d err=0", high, errs, UNLOCK_CYCLES);
    end
  endtask

  task automatic test_wrong_code();
    bit pat[4] = '{1, 0, 1, 1};
    int pulses = 0;
    for (int p = 0; p < DIGITS; p++) begin
      tick(1, 0, 0, pat[p]);
      pulses += err;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrong_press%0d got=%b want=%b", p, obs, exp_vec());
      end
      tick(0, 0, 0, 1);
      pulses += err;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrong_gap%0d got=%b want=%b", p, obs, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || fail_cnt !== 3'd1 || digit_idx !== 3'd0 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL wrong_result got pulses=%0d fc=%0d idx=%0d unl=%0b want 1,1,0,0",
               pulses, fail_cnt, digit_idx, unlocked);
    end
  endtask

  task automatic test_lockout();
    int lk = 0;
    tick(0, 0, 1, 1);
    for (int f = 0; f < MAX_FAILS; f++) begin
      for (int p = 0; p < DIGITS; p++) begin
        tick(1, 0, 0, p != 2);
        lk += locked_out;
        tick(0, 0, 0, 1);
        lk += locked_out;
      end
    end
    // Pound on enter and clear during the penalty.
    for (int c = 0; c < 20; c++) begin
      tick(c % 2 == 0, c == 5, 0, 1);
      lk += locked_out;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL lockout_cyc%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    checks++;
    if (lk != LOCKOUT_CYCLES || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL lockout_len got cycles=%0d fc=%0d want %0d,0", lk, fail_cnt, LOCKOUT_CYCLES);
    end
    for (int p = 0; p < DIGITS; p++) begin
      tick(1, 0, 0, 1);
      tick(0, 0, 0, 1);
    end
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL lockout_then_unlock got unl=%0b want 1", unlocked);
    end
    for (int c = 0; c < UNLOCK_CYCLES; c++) tick(0, 0, 0, 1);
  endtask

  task automatic test_clear();
    // One rejected code so fail_cnt is nonzero across the clear.
    for (int p = 0; p < DIGITS; p++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 1);
    end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(1, 1, 0, 1);
    checks++;
    if (obs !== exp_vec() || digit_idx !== 3'd0 || fail_cnt !== 3'd1) begin
      errors++;
      $display("FAIL clear_abort got=%b want=%b", obs, exp_vec());
    end
    tick(0, 0, 0, 1);
    for (int p = 0; p < DIGITS; p++) begin
      tick(1, 0, 0, 1);
      tick(0, 0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL clear_then%0d got=%b want=%b", p, obs, exp_vec());
      end
    end
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL clear_unlock got unl=%0b want 1", unlocked);
    end
  endtask

  task automatic test_enter_through_reset();
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    for (int c = 0; c < 3; c++) tick(1, 0, 0, 1);
    checks++;
    if (digit_idx !== 3'd0) begin
      errors++;
      $display("FAIL held_enter got idx=%0d want 0", digit_idx);
    end
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    checks++;
    if (digit_idx !== 3'd1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL held_enter_rise got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_reset_in_open();
    tick(0, 0, 1, 1);
    for (int p = 0; p < DIGITS; p++) begin
      tick(0, 0, 0, 1);
      tick(1, 0, 0, 1);
    end
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL open_before_rst got unl=%0b want 1", unlocked);
    end
    tick(0, 0, 1, 1);
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL rst_in_open got=%b want=%b", obs, 9'd0);
    end
  endtask

  task automatic test_random();
    bit en = 0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 1) == 1) en = ~en;
      tick(en, $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0,
           $urandom_range(0, 99) < 80);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d got=%b want=%b (idx,unl,lck,err,fc)", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) code[i] = 2'($urandom_range(0, 3));
    test_reset();
    test_unlock();
    test_wrong_code();
    test_lockout();
    test_clear();
    test_enter_through_reset();
    test_reset_in_open();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/code_lock_seq.md
Name: code_lock_seq

Overview:
- Sequential code-entry controller that sits directly downstream of the 2-bit equality comparator (XNOR pair into AND).
- Steps a digit index that selects which stored code digit the comparator checks against the switch inputs.
- On each debounced "enter" press, samples the comparator's eq result; after a full code, drives an unlock indicator or counts a failure.
- Enforces a lockout after repeated failures.

Parameters:
- DIGITS, 4, number of 2-bit digits in the code (2..8)
- IDX_W, 3, width of digit_idx; must satisfy 2**IDX_W >= DIGITS
- MAX_FAILS, 3, consecutive failed codes that trigger lockout (1..7)
- UNLOCK_CYCLES, 8, cycles unlocked stays high
- LOCKOUT_CYCLES, 16, cycles presses are ignored during lockout

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enter  in  1  level from push switch; rising edge = one digit entry
- clear  in  1  abort current entry (level, sampled each cycle)
- eq  in  1  comparator output for the currently selected digit
- digit_idx  out  IDX_W  index of code digit presented to comparator
- unlocked  out  1  LED drive; high while in OPEN
- locked_out  out  1  high while in LOCKOUT
- err  out  1  one-cycle pulse when a full code is rejected
- fail_cnt  out  3  consecutive failed codes

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=ENTRY; digit_idx=0; mismatch=0; fail_cnt=0; unlocked=0; locked_out=0; err=0; timer=0.
  - enter_q=1, so a switch held high through reset does not register a press.
- Press detect: press = enter & ~enter_q. enter_q <= enter every cycle, in all states.
- eq is sampled in the same cycle as press; the comparator path is combinational from digit_idx, so eq is valid one cycle after any digit_idx change.
- err defaults to 0 every cycle; it pulses only as described below.
- State ENTRY:
  - clear=1: digit_idx<=0, mismatch<=0, fail_cnt unchanged. Clear beats a simultaneous press; the press is discarded.
  - press with digit_idx<DIGITS-1: mismatch<=mismatch|~eq; digit_idx++.
  - press with digit_idx==DIGITS-1 and (mismatch|~eq)==0: go to OPEN; fail_cnt<=0; timer<=UNLOCK_CYCLES-1; digit_idx<=0; mismatch<=0.
  - press with digit_idx==DIGITS-1 and (mismatch|~eq)==1: err<=1 for one cycle; digit_idx<=0; mismatch<=0; fail_cnt++.
    - If fail_cnt+1==MAX_FAILS: go to LOCKOUT; timer<=LOCKOUT_CYCLES-1.
- State OPEN:
  - unlocked=1; presses are ignored.
  - Timer decrements each cycle; at timer==0 go to ENTRY.
  - clear=1 goes to ENTRY immediately (next cycle unlocked=0).
- State LOCKOUT:
  - locked_out=1; presses and clear are ignored.
  - Timer decrements; at timer==0 go to ENTRY with fail_cnt<=0.
- Output timing:
  - unlocked and locked_out are registered (state-decoded flops): high exactly UNLOCK_CYCLES / LOCKOUT_CYCLES cycles, starting the cycle after the deciding press.
  - err is high in that same following cycle.
- fail_cnt saturates at MAX_FAILS; it never wraps.
- A wrong digit mid-code gives no early indication. The full DIGITS presses are always required before err, so the failing position is not leaked.
- Reset mid-OPEN or mid-LOCKOUT: all outputs return to reset values at the next edge, including fail_cnt=0.

Decomposition:
- Shared package lock_pkg holds:
  - state enum {ENTRY, OPEN, LOCKOUT}, 2-bit encoding;
  - default parameter constants.
- One sub-module is natural: edge_detect (enter -> press), with reset value of the delayed flop = 1.
- Timer and FSM stay in code_lock_seq.

Test Plan (DIGITS=4, MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16):
- 4 presses with eq=1 -> digit_idx 0,1,2,3,0; unlocked high for exactly 8 cycles starting the cycle after press 4; fail_cnt=0; err never high.
- Presses with eq=1,0,1,1 -> no err until press 4; err single-cycle pulse; fail_cnt=1; digit_idx=0; unlocked stays 0.
- Three failed codes -> fail_cnt=3, locked_out high 16 cycles, presses during lockout leave digit_idx=0; afterwards fail_cnt=0 and a correct code unlocks.
- Two presses, then clear asserted in the same cycle as press 3 -> digit_idx=0, mismatch cleared, fail_cnt unchanged; next 4 good presses unlock.
- enter held high across rst deassert -> no press counted (digit_idx stays 0) until enter drops and rises again.
- Assert rst in the 4th cycle of OPEN -> next cycle unlocked=0, state ENTRY, all counters 0.
